// File: rtl/clock_pkg.sv
// Shared definitions for the gated-clock sequencer: state encoding and default widths.
package clock_pkg;

    // Default width of the burst length input and burst down-counter.
    localparam int DEFAULT_COUNT_WIDTH = 16;
    // Default width of the enabled-cycle counter.
    localparam int DEFAULT_CYCLE_WIDTH = 32;

    // Sequencer states; the encoding is visible on o_state, so it is fixed explicitly.
    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        BURST  = 2'd3
    } state_e;

endpackage

// File: rtl/burst_counter.sv
// Loadable down-counter holding the number of enabled cycles left in a burst.
module burst_counter
    import clock_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_load,
    input  logic [COUNT_WIDTH-1:0] i_value,
    input  logic                   i_dec,
    input  logic                   i_clear,
    output logic                   o_last
);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Next count: clear wins over load, load wins over decrement.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_value;
        end else if (i_dec) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    // Count register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The final enabled cycle of a burst is the one where the count reads 1.
    assign o_last = (count_q == COUNT_WIDTH'(1));

endmodule

// File: rtl/clock_controller.sv
// Sequencer deciding when the system clock gate is enabled: free-run, single-step,
// N-cycle burst and halt. Runs on the ungated clock; o_enable feeds the gate.
module clock_controller
    import clock_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int CYCLE_WIDTH = DEFAULT_CYCLE_WIDTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_burst,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic                   i_halt,
    input  logic                   i_trap,
    output logic                   o_enable,
    output logic [1:0]             o_state,
    output logic                   o_done,
    output logic [CYCLE_WIDTH-1:0] o_cycles
);

    state_e                 state_q, state_d;
    logic                   enable_q, enable_d;
    logic                   done_q, done_d;
    logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;

    logic burst_load;
    logic burst_dec;
    logic burst_clear;
    logic burst_last;
    logic stop_req;

    // Either halt source forces a return to HALTED from any active state.
    assign stop_req = i_halt | i_trap;

    burst_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_burst_counter (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .i_load   (burst_load),
        .i_value  (i_count),
        .i_dec    (burst_dec),
        .i_clear  (burst_clear),
        .o_last   (burst_last)
    );

    // Next-state, registered-output and burst-counter control decisions.
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        burst_load  = 1'b0;
        burst_dec   = 1'b0;
        burst_clear = 1'b0;

        unique case (state_q)
            HALTED: begin
                // Commands only count while nothing is holding the clock stopped.
                if (!stop_req) begin
                    if (i_run) begin
                        state_d = RUN;
                    end else if (i_burst) begin
                        if (i_count != '0) begin
                            state_d    = BURST;
                            burst_load = 1'b1;
                        end else begin
                            // Zero-length burst completes at once; a held request must not
                            // produce back-to-back done pulses.
                            done_d = ~done_q;
                        end
                    end else if (i_step) begin
                        state_d = STEP;
                    end
                end
            end
            RUN: begin
                if (stop_req) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                end
            end
            STEP: begin
                // A step lasts exactly one enabled cycle whether or not a halt arrives.
                state_d = HALTED;
                done_d  = 1'b1;
            end
            BURST: begin
                if (stop_req || burst_last) begin
                    // Leftover count is discarded so the next burst starts clean.
                    state_d     = HALTED;
                    done_d      = 1'b1;
                    burst_clear = 1'b1;
                end else begin
                    burst_dec = 1'b1;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        // The gate enable leads the state by nothing: it is registered alongside it.
        enable_d = (state_d != HALTED);
        cycles_d = enable_q ? (cycles_q + CYCLE_WIDTH'(1)) : cycles_q;
    end

    // State, enable, done and cycle-count registers; reset drops the enable immediately.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= HALTED;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            done_q   <= done_d;
            cycles_q <= cycles_d;
        end
    end

    assign o_enable = enable_q;
    assign o_state  = state_q;
    assign o_done   = done_q;
    assign o_cycles = cycles_q;

endmodule

// File: doc/clock_controller.md
Name: clock_controller

Overview:
- Sequencer for the gated system clock: decides when the clock gate's enable input is asserted.
- Supports free-run, single-step, N-cycle burst and halt, for CPU bring-up and debug.
- Runs on the free-running (ungated) clock; o_enable drives the gate's enable input.
- The gate only changes state on a rising edge, so enabled cycles map 1:1 to gated clock pulses.

Parameters:
- COUNT_WIDTH, 16, width of burst length input and burst down-counter.
- CYCLE_WIDTH, 32, width of the enabled-cycle counter o_cycles.

Ports:
- i_clock  input  1  free-running clock; all state updates on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_run  input  1  command: enter continuous run.
- i_step  input  1  command: one enabled cycle.
- i_burst  input  1  command: i_count enabled cycles.
- i_count  input  COUNT_WIDTH  burst length, sampled with i_burst.
- i_halt  input  1  operator halt; level-sensitive.
- i_trap  input  1  CPU halt request (HLT executed); level-sensitive.
- o_enable  output  1  clock gate enable; registered.
- o_state  output  2  current FSM state.
- o_done  output  1  one-cycle pulse on every return to HALTED.
- o_cycles  output  CYCLE_WIDTH  count of cycles with o_enable=1.

Behaviour:
- Reset (async assert, sync release): state=HALTED, o_enable=0, o_done=0, o_cycles=0, burst counter=0.
- States (2-bit): HALTED=0, RUN=1, STEP=2, BURST=3.
- o_enable is 1 in RUN, STEP and BURST, and 0 in HALTED. It is a register, not decoded from the state combinationally.
- Latency: a command sampled at edge k gives o_enable=1 from edge k onward, i.e. it is visible during cycle k+1.
- Priority each edge: i_halt > i_trap > commands.
- When i_halt or i_trap is high in a non-HALTED state:
  - next state HALTED, o_enable=0, o_done pulses.
  - This applies mid-burst and mid-step too; the remaining burst count is discarded (counter cleared).
- Commands are accepted only in HALTED with i_halt=0 and i_trap=0. Simultaneous commands resolve as i_run > i_burst > i_step.
- Commands arriving in a non-HALTED state are ignored, with no queuing.
- HALTED -> RUN on i_run. RUN stays until halt or trap.
- HALTED -> STEP on i_step:
  - exactly one cycle with o_enable=1;
  - the next edge moves to HALTED with o_done=1 for one cycle.
- HALTED -> BURST on i_burst with i_count=N>0:
  - counter loads N; o_enable is high for exactly N cycles;
  - counter decrements each BURST cycle;
  - at count=1 the next state is HALTED and o_done pulses.
- i_burst with i_count=0: state stays HALTED, o_enable stays 0, o_done pulses once on the next cycle (a zero-length burst completes immediately).
- N = 2^COUNT_WIDTH-1 is legal; no overflow handling is needed.
- o_cycles increments on every edge where o_enable=1, wrapping modulo 2^CYCLE_WIDTH (all-ones -> 0). It is cleared only by reset.
- o_done: registered, high for exactly one cycle per HALTED entry, and never high in two consecutive cycles.
- Reset asserted mid-operation: o_enable drops immediately (asynchronous) and all state is lost.
- A level-held i_run/i_step/i_burst after the block returns to HALTED re-triggers on the next edge. Edge detection is the requester's job.

Decomposition:
- Package clock_pkg:
  - state encoding constants HALTED/RUN/STEP/BURST;
  - state typedef (2-bit);
  - default widths COUNT_WIDTH/CYCLE_WIDTH.
- One sub-module, burst_counter: a loadable COUNT_WIDTH down-counter with load, decrement, clear and a last (count==1) flag. The FSM and cycle counter stay in clock_controller.

Test Plan:
- Reset with all inputs 0 -> o_enable=0, o_state=0, o_cycles=0, o_done=0; no change for 10 cycles.
- i_step pulse -> o_enable high exactly 1 cycle, o_done pulse the following cycle, o_cycles=1; a second i_step gives o_cycles=2.
- i_burst with i_count=5 -> o_enable high exactly 5 consecutive cycles, o_done one cycle after, o_cycles=5. Then i_count=0 -> o_enable never high, o_done pulses once, o_cycles stays 5.
- i_run, then i_trap high after 7 enabled cycles -> o_enable drops that edge, o_state=0, o_done pulse, o_cycles=7. An i_step asserted with i_trap still high is ignored.
- i_burst with i_count=100, i_halt after 10 enabled cycles -> o_cycles=10, o_done pulse. Then i_burst with i_count=3 -> exactly 3 more (o_cycles=13), proving the counter was cleared. i_run+i_step together in HALTED -> RUN chosen.
- CYCLE_WIDTH=4, run for 17 enabled cycles -> o_cycles wraps to 1. Async reset mid-run -> o_enable=0 before the next edge.
